// File: rtl/bgr_trim_sar_ctrl.sv
// Successive-approximation trim controller for the bandgap reference trim DAC.
// Define BGR_TRIM_AVG_EN to decide each bit by a 3-sample majority vote.
//
// state  | meaning
// IDLE   | waiting for a start edge, trim_code holds its last value
// SETTLE | trial bit applied, waiting for the analog path to settle
// SAMPLE | capture the comparator and resolve the current bit
// DONE   | search finished, result and done held until the next start edge
module bgr_trim_sar_ctrl #(
   parameter int TRIM_W     = 6,
   parameter int SETTLE_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic              cmp,
   output logic [TRIM_W-1:0] trim_code,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;
   localparam logic [TRIM_W-1:0] MID_CODE = {1'b1, {(TRIM_W-1){1'b0}}};
   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(TRIM_W - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [TRIM_W-1:0] trim, trim_nxt;
   logic              cmp_m, cmp_s;
   logic              start_q, start_arm, start_edge;
   logic              decide, decide_vld;
`ifdef BGR_TRIM_AVG_EN
   logic [1:0]        smp_cnt, smp_cnt_nxt;
   logic [1:0]        votes, votes_nxt;
`endif

   // start_arm keeps a start line still high across a reset from counting as an edge
   assign start_edge = start & ~start_q & start_arm;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      idx_nxt    = idx;
      trim_nxt   = trim;
      decide     = cmp_s;
      decide_vld = 1'b1;
`ifdef BGR_TRIM_AVG_EN
      smp_cnt_nxt = smp_cnt;
      votes_nxt   = votes;
`endif
      case (state)
         IDLE, DONE: begin
            if (start_edge) begin
               trim_nxt  = MID_CODE;
               idx_nxt   = IDX_TOP;
               cnt_nxt   = CNT_LOAD;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == 8'd0) begin
               state_nxt = SAMPLE;
`ifdef BGR_TRIM_AVG_EN
               smp_cnt_nxt = 2'd0;
`endif
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         SAMPLE: begin
`ifdef BGR_TRIM_AVG_EN
            if (smp_cnt != 2'd2) begin
               votes_nxt[smp_cnt[0]] = cmp_s;
               smp_cnt_nxt = smp_cnt + 2'd1;
               decide_vld  = 1'b0;
            end else begin
               decide = (votes[0] & votes[1]) | (votes[0] & cmp_s) | (votes[1] & cmp_s);
            end
`endif
            if (decide_vld) begin
               if (decide) trim_nxt[idx] = 1'b0;
               if (idx == '0) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt                = idx - 1'b1;
                  trim_nxt[idx - 1'b1]   = 1'b1;
                  cnt_nxt                = CNT_LOAD;
                  state_nxt              = SETTLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         idx       <= '0;
         trim      <= MID_CODE;
         cmp_m     <= 1'b0;
         cmp_s     <= 1'b0;
         start_q   <= 1'b0;
         start_arm <= 1'b0;
`ifdef BGR_TRIM_AVG_EN
         smp_cnt   <= 2'd0;
         votes     <= 2'd0;
`endif
      end else if (ena) begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         trim    <= trim_nxt;
         cmp_m   <= cmp;
         cmp_s   <= cmp_m;
         start_q <= start;
         if (!start) start_arm <= 1'b1;
`ifdef BGR_TRIM_AVG_EN
         smp_cnt <= smp_cnt_nxt;
         votes   <= votes_nxt;
`endif
      end
   end

   assign trim_code = trim;
   assign busy      = (state == SETTLE) || (state == SAMPLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_bgr_trim_sar_ctrl.sv
// Directed plus randomized bench for bgr_trim_sar_ctrl (default build, single-sample decision).
module tb_bgr_trim_sar_ctrl;
   localparam int TRIM_W     = 6;
   localparam int SETTLE_CYC = 16;
   localparam int MAX_CODE   = (1 << TRIM_W) - 1;
   localparam int MID        = 1 << (TRIM_W - 1);
   localparam int DONE_EDGE  = TRIM_W * (SETTLE_CYC + 1);

   logic              clk = 1'b0;
   logic              rst_n, ena, start;
   logic              cmp;
   logic [TRIM_W-1:0] trim_code;
   logic              busy, done;
   int                thr;
   int                n_cmp = 0;
   int                n_bad = 0;

   bgr_trim_sar_ctrl #(.TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .start     (start),
      .cmp       (cmp),
      .trim_code (trim_code),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // monotone DAC + comparator: too high whenever code exceeds the threshold
   assign cmp = (int'(trim_code) > thr);

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // largest code the comparator does not call too high
   function automatic int sar_ref(input int t);
      int best = 0;
      for (int c = 0; c <= MAX_CODE; c++)
         if (!(c > t)) best = c;
      return best;
   endfunction

   task automatic run(input string tag, input int t, input int gap_at, input int gap_len,
                      input int pulse_at, input bit hold);
      int  got = -1;
      bit  busy_ok = 1'b1;
      thr = t;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_busy_e0"}, int'(busy), 1);
      check({tag, "_done_e0"}, int'(done), 0);
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (!hold) start = (pulse_at > 0) && (k == pulse_at);
         ena = !(gap_len > 0 && k >= gap_at && k < gap_at + gap_len);
         @(posedge clk); #1;
         if (done) begin
            got = k;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      ena = 1'b1;
      check({tag, "_done_edge"}, got, DONE_EDGE + gap_len);
      check({tag, "_result"}, int'(trim_code), sar_ref(t));
      check({tag, "_busy_end"}, int'(busy), 0);
      check({tag, "_busy_held"}, int'(busy_ok), 1);
   endtask

   initial begin
      rst_n = 1'b1;
      ena   = 1'b1;
      start = 1'b0;
      thr   = 37;
      #2 rst_n = 1'b0;
      #1;
      check("rst_trim", int'(trim_code), MID);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      #10 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      run("nom37", 37, 0, 0, 0, 1'b0);
      run("cross0", 0, 0, 0, 0, 1'b0);
      run("cross63", 63, 0, 0, 0, 1'b0);
      run("gap", 37, 40, 10, 0, 1'b0);
      run("pulse_busy", 37, 0, 0, 50, 1'b0);
      run("hold", 37, 0, 0, 0, 1'b1);

      repeat (30) @(posedge clk);
      #1;
      check("hold_done", int'(done), 1);
      check("hold_busy", int'(busy), 0);
      check("hold_trim", int'(trim_code), 37);

      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check("retrig_busy", int'(busy), 1);
      check("retrig_done", int'(done), 0);
      check("retrig_trim", int'(trim_code), MID);

      repeat (50) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_trim", int'(trim_code), MID);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      #10 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("postrst_busy", int'(busy), 0);
      check("postrst_done", int'(done), 0);
      check("postrst_trim", int'(trim_code), MID);

      @(negedge clk); start = 1'b0;
      @(posedge clk);
      for (int r = 0; r < 6; r++) begin
         int t  = int'($urandom_range(0, 70));
         int ga = int'($urandom_range(1, 90));
         int gl = int'($urandom_range(0, 8));
         int pa = int'($urandom_range(0, 90));
         run($sformatf("rnd%0d", r), t, ga, gl, pa, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
